// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl
//   Duty-cycle controller and period sequencer for the PWM output stage.
//   Owns the PWM period counter and the active duty register. Duty targets
//   arrive from a host valid/ready port or from debounced incr/decr buttons;
//   the active duty is ramped toward the target one step per STEP_DIV
//   periods, and only ever changes on a period boundary so PWM_Out never
//   carries a truncated or glitched pulse.
//
//   Optional build macro PWM_SOFTSTART_EN: when defined, reset loads
//   duty_active=0 in the RAMP state so the output ramps up from zero to
//   DEFAULT_DUTY. When undefined, reset loads DEFAULT_DUTY directly in IDLE.
//
// Ports
//   clock        system clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   incr_duty    raw push-button, raises target by 1
//   decr_duty    raw push-button, lowers target by 1
//   req_valid    host duty request valid
//   req_duty     host requested duty (clamped to PERIOD)
//   req_ready    controller idle and able to accept a host request
//   duty_active  duty currently driving PWM_Out
//   busy         ramp in progress
//   period_start high while the period counter is 0
//   PWM_Out      PWM waveform, high while counter < duty_active

module pwm_duty_ramp_ctrl #(
  parameter int unsigned PERIOD       = 10,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned DEFAULT_DUTY = 5,
  parameter int unsigned STEP_DIV     = 2,
  parameter int unsigned DEBOUNCE_DIV = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              incr_duty,
  input  logic              decr_duty,
  input  logic              req_valid,
  input  logic [DUTY_W-1:0] req_duty,
  output logic              req_ready,
  output logic [DUTY_W-1:0] duty_active,
  output logic              busy,
  output logic              period_start,
  output logic              PWM_Out
);

  localparam int unsigned DB_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int unsigned ST_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DEF_V    = DUTY_W'(DEFAULT_DUTY);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_DIV - 1);
  localparam logic [ST_W-1:0]   ST_LAST  = ST_W'(STEP_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

`ifdef PWM_SOFTSTART_EN
  localparam state_t            RST_STATE = RAMP;
  localparam logic [DUTY_W-1:0] RST_DUTY  = '0;
`else
  localparam state_t            RST_STATE = IDLE;
  localparam logic [DUTY_W-1:0] RST_DUTY  = DEF_V;
`endif

  // ---------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------
  logic [DUTY_W-1:0] cnt;
  logic              wrap;

  assign wrap = (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Button debounce: both buttons are sampled on a shared slow tick; an
  // edge is reported when the latest sample is high and the one before
  // it was low.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            tick;
  logic            inc_q1, inc_q2;
  logic            dec_q1, dec_q2;
  logic            incr_edge, decr_edge;

  assign tick      = (db_cnt == DB_LAST);
  assign incr_edge = tick & inc_q1 & ~inc_q2;
  assign decr_edge = tick & dec_q1 & ~dec_q2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt <= '0;
      inc_q1 <= 1'b0;
      inc_q2 <= 1'b0;
      dec_q1 <= 1'b0;
      dec_q2 <= 1'b0;
    end else begin
      db_cnt <= tick ? '0 : db_cnt + 1'b1;
      if (tick) begin
        inc_q1 <= incr_duty;
        inc_q2 <= inc_q1;
        dec_q1 <= decr_duty;
        dec_q2 <= dec_q1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_t            state, state_next;
  logic [DUTY_W-1:0] target, target_next;
  logic [DUTY_W-1:0] duty_q, duty_next;
  logic [DUTY_W-1:0] duty_step;
  logic [ST_W-1:0]   step_cnt, step_next;
  logic              host_accept;

  assign req_ready   = (state == IDLE);
  assign busy        = (state == RAMP);
  assign host_accept = req_valid & req_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_STATE;
      target   <= DEF_V;
      duty_q   <= RST_DUTY;
      step_cnt <= '0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      duty_q   <= duty_next;
      step_cnt <= step_next;
    end
  end

  always_comb begin
    state_next  = state;
    target_next = target;
    duty_next   = duty_q;
    step_next   = step_cnt;
    duty_step   = duty_q;

    unique case (state)
      IDLE: begin
        // Priority host > incr > decr; losers in the same cycle are dropped.
        if (host_accept) begin
          target_next = (req_duty > PERIOD_V) ? PERIOD_V : req_duty;
        end else if (incr_edge) begin
          target_next = (target >= PERIOD_V) ? PERIOD_V : target + 1'b1;
        end else if (decr_edge) begin
          target_next = (target == '0) ? '0 : target - 1'b1;
        end
        if (target_next != duty_q) begin
          state_next = RAMP;
          step_next  = '0;
        end
      end

      RAMP: begin
        if (duty_q == target) begin
          // Only reachable from a soft-start reset with nothing to ramp.
          state_next = IDLE;
        end else if (wrap) begin
          if (step_cnt == ST_LAST) begin
            step_next  = '0;
            duty_step  = (target > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
            duty_next  = duty_step;
            // Leave RAMP on the same edge as the final step so busy and
            // req_ready change together with duty_active.
            if (duty_step == target) begin
              state_next = IDLE;
            end
          end else begin
            step_next = step_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs decoded from registers
  // ---------------------------------------------------------------------
  assign duty_active  = duty_q;
  assign period_start = (cnt == '0);
  assign PWM_Out      = (cnt < duty_q);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: directed scenarios followed by
// randomized host requests, button activity and asynchronous resets, all
// compared every cycle against a behavioural reference model.
module tb_pwm_duty_ramp_ctrl;

  localparam int PERIOD       = 10;
  localparam int DUTY_W       = 4;
  localparam int DEFAULT_DUTY = 5;
  localparam int STEP_DIV     = 2;
  localparam int DEBOUNCE_DIV = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              incr_duty;
  logic              decr_duty;
  logic              req_valid;
  logic [DUTY_W-1:0] req_duty;
  logic              req_ready;
  logic [DUTY_W-1:0] duty_active;
  logic              busy;
  logic              period_start;
  logic              PWM_Out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_cnt;       // position inside the PWM period
  int m_duty;      // active duty
  int m_target;    // requested duty
  int m_ramp;      // 1 while a ramp is in progress
  int m_bounds;    // period boundaries seen since ramp entry / last step
  int m_phase;     // clocks since the last button-sampling tick
  int inc_s[2];    // [0] newest button sample, [1] the one before
  int dec_s[2];

  pwm_duty_ramp_ctrl #(
    .PERIOD      (PERIOD),
    .DUTY_W      (DUTY_W),
    .DEFAULT_DUTY(DEFAULT_DUTY),
    .STEP_DIV    (STEP_DIV),
    .DEBOUNCE_DIV(DEBOUNCE_DIV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .incr_duty   (incr_duty),
    .decr_duty   (decr_duty),
    .req_valid   (req_valid),
    .req_duty    (req_duty),
    .req_ready   (req_ready),
    .duty_active (duty_active),
    .busy        (busy),
    .period_start(period_start),
    .PWM_Out     (PWM_Out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_target = DEFAULT_DUTY;
    m_bounds = 0;
    m_phase  = 0;
    inc_s    = '{0, 0};
    dec_s    = '{0, 0};
`ifdef PWM_SOFTSTART_EN
    m_duty = 0;
    m_ramp = (DEFAULT_DUTY != 0) ? 1 : 0;
`else
    m_duty = DEFAULT_DUTY;
    m_ramp = 0;
`endif
  endtask

  // One rising edge of the reference, using the inputs present at that edge.
  task automatic model_step();
    bit tick, inc_e, dec_e;
    int nt;
    tick  = (m_phase == DEBOUNCE_DIV - 1);
    inc_e = tick && inc_s[0] == 1 && inc_s[1] == 0;
    dec_e = tick && dec_s[0] == 1 && dec_s[1] == 0;
    if (m_ramp == 0) begin
      nt = m_target;
      if (req_valid) nt = (int'(req_duty) > PERIOD) ? PERIOD : int'(req_duty);
      else if (inc_e) nt = (m_target + 1 > PERIOD) ? PERIOD : m_target + 1;
      else if (dec_e) nt = (m_target > 0) ? m_target - 1 : 0;
      m_target = nt;
      if (m_target != m_duty) begin
        m_ramp   = 1;
        m_bounds = 0;
      end
    end else if (m_cnt == PERIOD - 1) begin
      m_bounds++;
      if (m_bounds == STEP_DIV) begin
        m_bounds = 0;
        m_duty   = (m_target > m_duty) ? m_duty + 1 : m_duty - 1;
        if (m_duty == m_target) m_ramp = 0;
      end
    end
    if (tick) begin
      inc_s[1] = inc_s[0];
      inc_s[0] = int'(incr_duty);
      dec_s[1] = dec_s[0];
      dec_s[0] = int'(decr_duty);
    end
    m_phase = tick ? 0 : m_phase + 1;
    m_cnt   = (m_cnt + 1) % PERIOD;
  endtask

  task automatic compare_all();
    check("duty_active", 32'(duty_active), 32'(m_duty));
    check("busy", 32'(busy), 32'(m_ramp));
    check("req_ready", 32'(req_ready), 32'(m_ramp == 0));
    check("period_start", 32'(period_start), 32'(m_cnt == 0));
    check("PWM_Out", 32'(PWM_Out), 32'(m_cnt < m_duty));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick_cycle();
    @(posedge clock);
    if (reset_n) model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    incr_duty = 1'b0;
    decr_duty = 1'b0;
    req_valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    tick_cycle();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && m_ramp != 0; i++) tick_cycle();
    if (m_ramp != 0) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic host_req(input int d);
    req_valid = 1'b1;
    req_duty  = DUTY_W'(d);
    tick_cycle();
    req_valid = 1'b0;
  endtask

  initial begin
    int hold;
    reset_n   = 1'b1;
    incr_duty = 1'b0;
    decr_duty = 1'b0;
    req_valid = 1'b0;
    req_duty  = '0;
    @(negedge clock);
    do_reset();

`ifdef PWM_SOFTSTART_EN
    check("softstart_duty0", 32'(duty_active), 32'd0);
    check("softstart_busy", 32'(busy), 32'd1);
    wait_idle("softstart", 40 * PERIOD * STEP_DIV);
    check("softstart_final", 32'(duty_active), 32'(DEFAULT_DUTY));
`else
    check("reset_duty", 32'(duty_active), 32'(DEFAULT_DUTY));
`endif

    // Free-running periods with no inputs
    run(3 * PERIOD);

    // Host ramp up to 8
    host_req(8);
    check("host8_busy", 32'(busy), 32'd1);
    wait_idle("host8", 20 * PERIOD * STEP_DIV);
    check("host8_final", 32'(duty_active), 32'd8);

    // Over-range request clamps to full scale
    host_req(15);
    wait_idle("host15", 20 * PERIOD * STEP_DIV);
    check("host15_clamp", 32'(duty_active), 32'(PERIOD));
    run(PERIOD);
    incr_duty = 1'b1;
    run(10);
    incr_duty = 1'b0;
    run(10);
    check("incr_at_max_idle", 32'(busy), 32'd0);
    check("incr_at_max_duty", 32'(duty_active), 32'(PERIOD));

    // Host accept coinciding with an incr edge: host wins
    incr_duty = 1'b1;
    for (int i = 0; i < 40 && !(m_phase == DEBOUNCE_DIV - 1 && inc_s[0] == 1 && inc_s[1] == 0); i++)
      tick_cycle();
    host_req(2);
    incr_duty = 1'b0;
    wait_idle("host_vs_btn", 20 * PERIOD * STEP_DIV);
    check("host_over_btn", 32'(duty_active), 32'd2);

    // incr and decr together: incr wins
    incr_duty = 1'b1;
    decr_duty = 1'b1;
    run(4 * DEBOUNCE_DIV);
    incr_duty = 1'b0;
    decr_duty = 1'b0;
    wait_idle("incr_decr", 20 * PERIOD * STEP_DIV);
    check("incr_over_decr", 32'(duty_active), 32'd3);

    // One-clock press between sampling ticks is ignored
    run(4 * DEBOUNCE_DIV);
    for (int i = 0; i < 4 && m_phase == DEBOUNCE_DIV - 1; i++) tick_cycle();
    incr_duty = 1'b1;
    tick_cycle();
    incr_duty = 1'b0;
    run(20);
    check("short_press_busy", 32'(busy), 32'd0);
    check("short_press_duty", 32'(duty_active), 32'd3);

    // Reset in the middle of a ramp
    host_req(8);
    for (int i = 0; i < 20 * PERIOD * STEP_DIV && m_duty != 6; i++) tick_cycle();
    check("midramp_reached6", 32'(duty_active), 32'd6);
    reset_n   = 1'b0;
    #1;
`ifdef PWM_SOFTSTART_EN
    check("midramp_reset_duty", 32'(duty_active), 32'd0);
`else
    check("midramp_reset_duty", 32'(duty_active), 32'(DEFAULT_DUTY));
    check("midramp_reset_busy", 32'(busy), 32'd0);
`endif
    check("midramp_reset_cnt0", 32'(period_start), 32'd1);
    model_reset();
    @(negedge clock);
    tick_cycle();
    reset_n = 1'b1;
    wait_idle("post_reset", 40 * PERIOD * STEP_DIV);

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        req_valid = ($urandom_range(0, 19) == 0);
        req_duty  = DUTY_W'($urandom_range(0, 15));
        if (hold == 0) begin
          incr_duty = ($urandom_range(0, 3) == 0);
          decr_duty = ($urandom_range(0, 3) == 0);
          hold      = $urandom_range(1, 12);
        end else begin
          hold--;
        end
        tick_cycle();
      end
    end
    req_valid = 1'b0;
    incr_duty = 1'b0;
    decr_duty = 1'b0;
    wait_idle("final", 40 * PERIOD * STEP_DIV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
